uart_rx: RTL and testbench
==========================

# uart_rx

Parametrised UART receiver with configurable frame format, 3-sample majority voting, parity/framing/break detection and a show-ahead output FIFO with valid/ready handshake. It sits between the board serial input pin and the game-logic command decoder. It replaces the fixed 8N1, single-sample, unbuffered receiver.

## Interface
- CLOCKS_PER_BIT, 10: clock cycles per serial bit; legal range ≥ 4.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ 2.
- clock  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, idle high, asynchronous to clock.
- rx_data  output  DATA_BITS  FIFO head data, LSB = first received bit.
- rx_valid  output  1  FIFO non-empty; head entry on rx_data/parity_err/frame_err.
- rx_ready  input  1  consumer pops head when rx_valid && rx_ready.
- parity_err  output  1  head entry parity mismatch; always 0 when PARITY = 0.
- frame_err  output  1  head entry had at least one stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed word dropped because FIFO full.
- break_det  output  1  one-cycle pulse: break condition detected.

## Operation
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs. A 3-bit history holds rxs for the current cycle and the two before it. The bit value is the majority of these three samples at each mid-bit tick.
- The FSM states are IDLE, START, DATA, PARITY, STOP and BREAK.
- IDLE: rxs = 0 loads bit counter with CLOCKS_PER_BIT/2 − 1 and goes to START.
- START: at counter 0 (mid-bit tick), a vote of 1 is a false start and returns to IDLE. A vote of 0 goes to DATA with bit index 0.
- Every later tick reloads the counter with CLOCKS_PER_BIT − 1.
- DATA: each tick shifts the vote into the shift register, LSB first. After DATA_BITS ticks, go to PARITY if PARITY ≠ 0, else STOP.
- PARITY: the vote is checked against the XOR of the data bits. Even parity requires the total count of ones to be even; odd parity requires it to be odd. A mismatch sets the parity flag.
- STOP: STOP_BITS ticks; any vote of 0 sets the frame flag. On the final stop tick:
  - If data = 0, the parity vote (if any) = 0 and every stop vote = 0: pulse break_det, no push, go to BREAK.
  - Otherwise push {parity flag, frame flag, data} and go to IDLE.
  - If the FIFO is full, the word is dropped and overrun pulses for one cycle.
- BREAK: stay until rxs = 1, then go to IDLE.
- Returning to IDLE at mid-stop-bit is required so that back-to-back frames are accepted.
- FIFO: registered head output (show-ahead).
  - Push and pop in the same cycle are both honoured when the FIFO is non-empty.
  - When the FIFO is full, a simultaneous pop frees space, so the push succeeds and no overrun occurs.
- Reset: every output is 0 (rx_data = 0, rx_valid = 0, all flags/pulses = 0). The FSM goes to IDLE, the FIFO is emptied and the synchroniser/history is set to all-ones. Reset mid-frame discards the partial frame.

## Timing
- A tick occurs CLOCKS_PER_BIT/2 + k·CLOCKS_PER_BIT cycles after the first cycle rxs = 0, plus 2 cycles of synchroniser delay from the pin.
- The push happens in the cycle after the final stop tick. rx_valid rises the cycle after the push.
- Pop: the next entry, or rx_valid = 0, appears the cycle after the handshake.
- overrun and break_det are high for exactly one cycle, aligned with the would-be push cycle.
- Counter width is clog2(CLOCKS_PER_BIT). FIFO pointers are clog2(FIFO_DEPTH)+1 bits with wrap-bit full/empty detection.

## Structure
- Shared package uart_pkg: parity mode constants (PARITY_NONE/EVEN/ODD) and the rx state enum typedef.
- Sub-module uart_rx_fifo holds the parametrised width/depth show-ahead FIFO, with word width DATA_BITS + 2. The FSM, synchroniser and vote logic live in the top.

## Test plan
- CLOCKS_PER_BIT = 16, 8E1, send 0xA5 with correct parity (0) -> rx_valid, rx_data = 0xA5, parity_err = 0, frame_err = 0; pop empties the FIFO.
- Same config, 0x3C with parity bit 1 -> rx_data = 0x3C, parity_err = 1. Then 0x81 with stop bit low -> frame_err = 1, no break_det.
- 3-cycle low glitch on idle line -> no push. A 1-cycle inverted glitch at the mid-sample of data bit 3 of 0x55 -> rx_data = 0x55 (vote masks it).
- rx held low for 2 frame times (8N1) -> break_det pulses once, no push, no frame_err. rx high again -> next frame 0x12 received normally.
- FIFO_DEPTH = 4, rx_ready = 0, send 0x01..0x05 back-to-back -> four entries held, overrun pulses once on 0x05. Drain -> 0x01, 0x02, 0x03, 0x04 in order.
- Assert reset during DATA of a frame, release before the next frame -> no push from the partial frame. Next frame 0xF0 is received correctly. DATA_BITS = 7, odd parity, 2 stop bits: 0x7F -> correct data, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver
// state encoding and the 3-sample majority vote helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Majority of three line samples; a single-cycle glitch cannot flip it.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for received words. The head entry is visible whenever the
// FIFO is non-empty; a push into a full FIFO is honoured only when the head is
// popped in the same cycle, otherwise the word is dropped and overrun pulses.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty_s, full_s, do_pop_s, do_push_s;

    // Pointer compare with wrap bit, handshake qualification and next pointers.
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop_s  = !empty_s && pop_ready;
        do_push_s = push && (!full_s || do_pop_s);
        overrun   = push && full_s && !do_pop_s;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        head_valid = !empty_s;
        if (empty_s) begin
            head_data = {WIDTH{1'b0}};
        end else begin
            head_data = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote at mid-bit,
// configurable data/parity/stop format, break detection and an output FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 10,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int WW = DATA_BITS + 2;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic          LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic          ODD_SEL   = (PARITY == PARITY_ODD) ? 1'b1 : 1'b0;

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           hist_q, hist_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 brk_ok_q, brk_ok_d;
    logic                 push_q, push_d;
    logic [WW-1:0]        word_q, word_d;
    logic                 break_q, break_d;
    logic                 rxs_s, vote_s, tick_s;
    logic [WW-1:0]        head_s;

    // Synchroniser, sample history and mid-bit vote.
    always_comb begin
        rxs_s  = sync_q[1];
        sync_d = {sync_q[0], rx};
        hist_d = {hist_q[0], rxs_s};
        vote_s = maj3({hist_q, rxs_s});
        tick_s = (cnt_q == {CW{1'b0}});
    end

    // Frame FSM: next state, bit timing, data assembly and error flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        brk_ok_d   = brk_ok_q;
        push_d     = 1'b0;
        word_d     = word_q;
        break_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (vote_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = {IW{1'b0}};
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    brk_ok_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d   = FULL_LOAD;
                    shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d     = FULL_LOAD;
                    state_d   = ST_STOP;
                    par_err_d = (vote_s != ((^shift_q) ^ ODD_SEL));
                    brk_ok_d  = brk_ok_q & ~vote_s;
                end
            end
            ST_STOP: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (stop_idx_q == LAST_STOP) begin
                    cnt_d = FULL_LOAD;
                    if ((shift_q == {DATA_BITS{1'b0}}) && brk_ok_q && !vote_s) begin
                        break_d = 1'b1;
                        state_d = ST_BREAK;
                    end else begin
                        push_d  = 1'b1;
                        word_d  = {par_err_q, frm_err_q | ~vote_s, shift_q};
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d      = FULL_LOAD;
                    stop_idx_d = 1'b1;
                    frm_err_d  = frm_err_q | ~vote_s;
                    brk_ok_d   = brk_ok_q & ~vote_s;
                end
            end
            ST_BREAK: begin
                if (rxs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; line history resets to idle-high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            hist_q     <= 2'b11;
            cnt_q      <= {CW{1'b0}};
            bit_idx_q  <= {IW{1'b0}};
            stop_idx_q <= 1'b0;
            shift_q    <= {DATA_BITS{1'b0}};
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            brk_ok_q   <= 1'b0;
            push_q     <= 1'b0;
            word_q     <= {WW{1'b0}};
            break_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            brk_ok_q   <= brk_ok_d;
            push_q     <= push_d;
            word_q     <= word_d;
            break_q    <= break_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_q),
        .push_data  (word_q),
        .pop_ready  (rx_ready),
        .head_data  (head_s),
        .head_valid (rx_valid),
        .overrun    (overrun)
    );

    // Split the head word into its data and error fields.
    always_comb begin
        rx_data    = head_s[DATA_BITS-1:0];
        frame_err  = head_s[DATA_BITS];
        parity_err = head_s[DATA_BITS+1];
        break_det  = break_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. Three receivers share a clock:
// inst 0 = 8E1, inst 1 = 7O2, inst 2 = 8N1 (all 16 clocks per bit, depth 4).
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx   [3];
    logic       rdy  [3];
    logic       val  [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       ov   [3];
    logic       bk   [3];
    logic [8:0] dat  [3];
    logic [7:0] dat_a;
    logic [6:0] dat_b;
    logic [7:0] dat_c;

    int checks = 0;
    int errors = 0;
    int brk_cnt [3];
    int ovr_cnt [3];
    logic [12:0] sb [$];

    always #5 clock = ~clock;

    uart_rx #(.CLOCKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clock(clock), .reset(reset), .rx(rx[0]), .rx_data(dat_a), .rx_valid(val[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .break_det(bk[0]));
    uart_rx #(.CLOCKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clock(clock), .reset(reset), .rx(rx[1]), .rx_data(dat_b), .rx_valid(val[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .break_det(bk[1]));
    uart_rx #(.CLOCKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clock(clock), .reset(reset), .rx(rx[2]), .rx_data(dat_c), .rx_valid(val[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .break_det(bk[2]));

    assign dat[0] = {1'b0, dat_a};
    assign dat[1] = {2'b00, dat_b};
    assign dat[2] = {1'b0, dat_c};

    function automatic logic [12:0] mk(input int inst, input logic p, input logic f, input logic [8:0] d);
        return {2'(inst), p, f, d};
    endfunction

    // Monitor: count pulse cycles and compare every popped head with the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (bk[i]) brk_cnt[i]++;
                if (ov[i]) ovr_cnt[i]++;
                if (val[i] && rdy[i]) begin
                    logic [12:0] got;
                    logic [12:0] want;
                    got = mk(i, pe[i], fe[i], dat[i]);
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL pop_unexpected inst %0d got %h required none", i, got);
                    end else begin
                        want = sb.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL pop inst %0d got %h required %h", i, got, want);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, got, want);
        end
    endtask

    task automatic drive(input int inst, input logic v, input int n);
        rx[inst] = v;
        repeat (n) @(negedge clock);
    endtask

    // One frame: start, data LSB first, optional parity, stop bits. gbit selects
    // a data bit that gets a one-cycle inverted glitch at its mid-sample point.
    task automatic send_frame(input int inst, input logic [8:0] d, input int nb, input int has_par,
                              input logic pbit, input int nstop, input logic sval, input int gbit);
        drive(inst, 1'b0, 16);
        for (int k = 0; k < nb; k++) begin
            if (k == gbit) begin
                drive(inst, d[k], 8);
                drive(inst, ~d[k], 1);
                drive(inst, d[k], 7);
            end else begin
                drive(inst, d[k], 16);
            end
        end
        if (has_par != 0) drive(inst, pbit, 16);
        for (int s = 0; s < nstop; s++) drive(inst, sval, 16);
        rx[inst] = 1'b1;
    endtask

    task automatic wait_empty(input string nm, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending required 0", nm, sb.size());
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic set_rdy(input int inst, input logic v);
        @(posedge clock);
        #1;
        rdy[inst] = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1;
            rdy[i] = 1'b1;
            brk_cnt[i] = 0;
            ovr_cnt[i] = 0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs", {26'd0, val[i], pe[i], fe[i], ov[i], bk[i], dat[i] != 9'd0}, 32'd0);
        end
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // 8E1: 0xA5 (four ones, parity 0) is clean; FIFO empties after the pop.
        sb.push_back(mk(0, 1'b0, 1'b0, 9'h0A5));
        send_frame(0, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, -1);
        wait_empty("a5", 200);
        chk("a5_empty_after_pop", {31'd0, val[0]}, 32'd0);

        // 0x3C with wrong parity bit, then 0x81 with low stop bit.
        sb.push_back(mk(0, 1'b1, 1'b0, 9'h03C));
        send_frame(0, 9'h03C, 8, 1, 1'b1, 1, 1'b1, -1);
        wait_empty("3c", 200);
        sb.push_back(mk(0, 1'b0, 1'b1, 9'h081));
        send_frame(0, 9'h081, 8, 1, 1'b0, 1, 1'b0, -1);
        wait_empty("81", 200);
        chk("81_no_break", brk_cnt[0], 32'd0);

        // Short idle glitch is a false start; mid-bit glitch on 0x55 is outvoted.
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 60);
        sb.push_back(mk(0, 1'b0, 1'b0, 9'h055));
        send_frame(0, 9'h055, 8, 1, 1'b0, 1, 1'b1, 3);
        wait_empty("55_glitch", 200);

        // 8N1 break: two frame times low, then a normal 0x12.
        drive(2, 1'b0, 320);
        drive(2, 1'b1, 32);
        chk("break_pulse_count", brk_cnt[2], 32'd1);
        chk("break_no_push", {31'd0, val[2]}, 32'd0);
        sb.push_back(mk(2, 1'b0, 1'b0, 9'h012));
        send_frame(2, 9'h012, 8, 0, 1'b0, 1, 1'b1, -1);
        wait_empty("12_after_break", 200);

        // FIFO overflow: five back-to-back frames with the consumer stalled.
        set_rdy(2, 1'b0);
        for (int w = 1; w <= 5; w++) begin
            if (w <= 4) sb.push_back(mk(2, 1'b0, 1'b0, 9'(w)));
            send_frame(2, 9'(w), 8, 0, 1'b0, 1, 1'b1, -1);
        end
        repeat (20) @(negedge clock);
        chk("overrun_count", ovr_cnt[2], 32'd1);
        chk("fifo_full_valid", {31'd0, val[2]}, 32'd1);
        set_rdy(2, 1'b1);
        wait_empty("drain", 50);
        chk("drained_valid", {31'd0, val[2]}, 32'd0);

        // Reset during DATA discards the partial frame; 0xF0 then arrives cleanly.
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 48);
        reset = 1'b1;
        rx[0] = 1'b1;
        repeat (3) @(negedge clock);
        chk("midframe_reset_valid", {31'd0, val[0]}, 32'd0);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        chk("midframe_no_push", {31'd0, val[0]}, 32'd0);
        sb.push_back(mk(0, 1'b0, 1'b0, 9'h0F0));
        send_frame(0, 9'h0F0, 8, 1, 1'b0, 1, 1'b1, -1);
        wait_empty("f0", 200);

        // 7O2: 0x7F has seven ones, so the odd parity bit is 0.
        sb.push_back(mk(1, 1'b0, 1'b0, 9'h07F));
        send_frame(1, 9'h07F, 7, 1, 1'b0, 2, 1'b1, -1);
        wait_empty("7f_7o2", 200);

        chk("no_overrun_a", ovr_cnt[0], 32'd0);
        chk("no_break_b", brk_cnt[1], 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
